// File: rtl/updown_sel_counter.sv
// Up/down counter driven by two debounced, auto-repeating push buttons.
// Bounds either saturate or wrap; EN is an active-low step enable.
module updown_sel_counter #(
    parameter int unsigned WIDTH         = 3,
    parameter int unsigned MAX_VAL       = 2**WIDTH-1,
    parameter int unsigned WRAP          = 0,
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned REPEAT_DELAY  = 0,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic             botton_up,
    input  logic             botton_down,
    output logic [WIDTH-1:0] Q,
    output logic             at_max,
    output logic             at_min,
    output logic             step
);

    typedef enum logic [1:0] {StIdle, StDeb, StHeld, StRepeat} btn_state_e;

    localparam logic [WIDTH-1:0] MaxQ      = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] OneQ      = WIDTH'(1);
    localparam logic [7:0]       DebTarget = 8'(DEB_CYCLES);
    localparam logic [31:0]      RepDelay  = 32'(REPEAT_DELAY);
    localparam logic [31:0]      RepPeriod = 32'(REPEAT_PERIOD);
    localparam bit               RepeatOn  = (REPEAT_DELAY != 0);
    localparam bit               WrapOn    = (WRAP != 0);

    logic [1:0] btn_raw;
    logic [1:0] req;

    assign btn_raw = {botton_down, botton_up};

    // Index 0 handles the up button, index 1 the down button.
    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic [1:0]  sync_q, sync_d;
        btn_state_e  state_q, state_d;
        logic [7:0]  deb_cnt_q, deb_cnt_d;
        logic [31:0] rep_cnt_q, rep_cnt_d;
        logic        in_s;
        logic        req_b;

        assign in_s = sync_q[1];

        always_comb begin
            sync_d    = {sync_q[0], btn_raw[b]};
            state_d   = state_q;
            deb_cnt_d = deb_cnt_q;
            rep_cnt_d = rep_cnt_q;
            req_b     = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_s) begin
                        // Loading 1 already meets a one-sample debounce.
                        if (DebTarget == 8'd1) begin
                            state_d   = StHeld;
                            deb_cnt_d = '0;
                            rep_cnt_d = '0;
                            req_b     = 1'b1;
                        end else begin
                            state_d   = StDeb;
                            deb_cnt_d = 8'd1;
                        end
                    end
                end
                StDeb: begin
                    if (!in_s) begin
                        state_d   = StIdle;
                        deb_cnt_d = '0;
                    end else if (deb_cnt_q + 8'd1 == DebTarget) begin
                        state_d   = StHeld;
                        deb_cnt_d = '0;
                        rep_cnt_d = '0;
                        req_b     = 1'b1;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 8'd1;
                    end
                end
                StHeld: begin
                    if (!in_s) begin
                        state_d   = StIdle;
                        rep_cnt_d = '0;
                    end else if (RepeatOn) begin
                        if (rep_cnt_q + 32'd1 == RepDelay) begin
                            state_d   = StRepeat;
                            rep_cnt_d = '0;
                            req_b     = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 32'd1;
                        end
                    end
                end
                StRepeat: begin
                    if (!in_s) begin
                        state_d   = StIdle;
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q + 32'd1 == RepPeriod) begin
                        rep_cnt_d = '0;
                        req_b     = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_d   = StIdle;
                    deb_cnt_d = '0;
                    rep_cnt_d = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q    <= '0;
                state_q   <= StIdle;
                deb_cnt_q <= '0;
                rep_cnt_q <= '0;
            end else begin
                sync_q    <= sync_d;
                state_q   <= state_d;
                deb_cnt_q <= deb_cnt_d;
                rep_cnt_q <= rep_cnt_d;
            end
        end

        assign req[b] = req_b;
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             step_q, step_d;

    // Requests while disabled are simply dropped; simultaneous up/down cancel.
    always_comb begin
        q_d = q_q;
        if (!EN) begin
            if (req[0] && !req[1]) begin
                if (q_q == MaxQ) begin
                    if (WrapOn) begin
                        q_d = '0;
                    end
                end else begin
                    q_d = q_q + OneQ;
                end
            end else if (req[1] && !req[0]) begin
                if (q_q == '0) begin
                    if (WrapOn) begin
                        q_d = MaxQ;
                    end
                end else begin
                    q_d = q_q - OneQ;
                end
            end
        end
        step_d = (q_d != q_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            step_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            step_q <= step_d;
        end
    end

    assign Q      = q_q;
    assign step   = step_q;
    assign at_max = (q_q == MaxQ);
    assign at_min = (q_q == '0);

endmodule

// File: doc/updown_sel_counter.md
UPDOWN_SEL_COUNTER -- requirements
Module: updown_sel_counter

Interface
REQ-001 Parameter WIDTH, default 3: width of count output Q.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: upper count bound; legal range 1..2**WIDTH-1.
REQ-003 Parameter WRAP, default 0: 0 = saturate at bounds, 1 = wrap around at bounds.
REQ-004 Parameter DEB_CYCLES, default 4: consecutive high synchronized samples required to accept a press; legal range 1..255.
REQ-005 Parameter REPEAT_DELAY, default 0: held cycles after first step before auto-repeat; 0 disables auto-repeat.
REQ-006 Parameter REPEAT_PERIOD, default 4: cycles between auto-repeat steps; legal range 1..65535.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 EN  input  1  active-low step enable: 0 = steps applied, 1 = Q frozen.
REQ-010 botton_up  input  1  asynchronous raw up button, active-high.
REQ-011 botton_down  input  1  asynchronous raw down button, active-high.
REQ-012 Q  output  WIDTH  current count.
REQ-013 at_max  output  1  high while Q == MAX_VAL.
REQ-014 at_min  output  1  high while Q == 0.
REQ-015 step  output  1  one-cycle pulse on the cycle following any edge at which Q changed.

Function
REQ-016 Each button SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-017 Each button SHALL have an independent FSM with states IDLE, DEB, HELD, REPEAT.
REQ-018 IDLE->DEB when the synchronized input is 1; the debounce counter loads 1.
REQ-019 DEB: the counter increments while the input is 1; any 0 sample returns the FSM to IDLE and clears the counter.
REQ-020 DEB->HELD when the counter reaches DEB_CYCLES; this transition issues one step request.
REQ-021 HELD: if REPEAT_DELAY>0, after REPEAT_DELAY cycles held, move to REPEAT and issue one step request; if REPEAT_DELAY=0, remain in HELD until release.
REQ-022 REPEAT: issue one step request every REPEAT_PERIOD cycles while held.
REQ-023 Input 0 in HELD or REPEAT SHALL return the FSM to IDLE next edge, with no step issued.
REQ-024 Latency from raw input rising (stable before edge 1) to Q change SHALL be DEB_CYCLES+2 edges.
REQ-025 Q SHALL update on the same edge the step request is issued: up +1, down -1, modulo WIDTH arithmetic only under the wrap rules.
REQ-026 Saturate mode (WRAP=0): an up request at MAX_VAL and a down request at 0 SHALL leave Q unchanged and SHALL NOT pulse step.
REQ-027 Wrap mode (WRAP=1): an up request at MAX_VAL SHALL load 0; a down request at 0 SHALL load MAX_VAL.
REQ-028 Up and down requests on the same edge SHALL cancel: Q is held and step stays 0.
REQ-029 Requests arriving while EN=1 SHALL be discarded, not queued; the FSMs keep running.
REQ-030 at_max and at_min SHALL be decoded combinationally from Q.

Reset
REQ-031 rst=1 at an edge SHALL set Q=0, step=0, both FSMs to IDLE, and clear the debounce/repeat counters and synchronizer flops.
REQ-032 Reset SHALL take priority over all other activity, including mid-debounce and mid-repeat.
REQ-033 After reset deasserts, a held button SHALL go through the full debounce before stepping.
REQ-034 Outputs after reset: Q=0, at_min=1, at_max=0, step=0.

Verification (bench params WIDTH=3, MAX_VAL=5, DEB_CYCLES=4, REPEAT_DELAY=16, REPEAT_PERIOD=4 unless noted)
REQ-035 Press botton_up for 3 cycles, then release: Q stays 0 and step never pulses (bounce rejected).
REQ-036 Hold botton_up from Q=0, WRAP=0: Q=1 at edge 6; then steps every 4 cycles after 16; saturates at 5 with at_max=1 and no further step pulses.
REQ-037 WRAP=1, Q=5, one clean up press: Q=0; then a down press: Q=5.
REQ-038 botton_up and botton_down rise on the same cycle, both held, REPEAT_DELAY=0: Q holds 0 and step stays 0.
REQ-039 EN=1 during an up press: Q unchanged. Set EN=0 while still held with REPEAT_DELAY=0: no step (request discarded).
REQ-040 Assert rst for 1 cycle mid-repeat at Q=3: Q=0 next edge; a continued hold steps Q to 1 after DEB_CYCLES+2 edges.
